// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Round-robin arbiter sharing one downstream resource among N requesters.
//   A grant is held until the owner pulses done, drops its request, or has
//   held the resource for MAX_HOLD cycles. At least one idle cycle always
//   separates two grants, so the gnt_idx mux select only moves while no
//   grant is active.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [N-1:0] request vector, bit i = requester i
//   done       in   owner releases the grant (only looked at in GRANT)
//   gnt        out  [N-1:0] one-hot grant, zero when idle
//   gnt_idx    out  [IDXW-1:0] binary index of the granted requester, 0 when idle
//   gnt_valid  out  high while a grant is active
//   timeout    out  one-cycle pulse after a grant is force-released by MAX_HOLD
module rr_grant_scheduler #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDXW     = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int unsigned CNTW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              sel_found;
    logic [IDXW-1:0]   sel_idx;
    logic              owner_req;
    logic              hold_hit;

    // Scan ptr, ptr+1, ... with natural IDXW-bit wrap; first set bit wins.
    always_comb begin
        logic [IDXW-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + IDXW'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign owner_req = req[gnt_idx_q];
    assign hold_hit  = (cnt_q == CNTW'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done is deliberately ignored here.
                if (sel_found) begin
                    state_d   = StGrant;
                    gnt_d     = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                    gnt_idx_d = sel_idx;
                    cnt_d     = CNTW'(1);
                end
            end
            StGrant: begin
                // Non-owner request bits play no part while a grant is held.
                if (done || !owner_req || hold_hit) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    ptr_d     = gnt_idx_q + IDXW'(1);
                    cnt_d     = '0;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_d = hold_hit && !done && owner_req;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                gnt_d     = '0;
                gnt_idx_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (N=4, MAX_HOLD=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_rr_grant_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_vec;
    int n_err;

    rr_grant_scheduler #(
        .N        (4),
        .IDXW     (2),
        .MAX_HOLD (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks all four outputs; an idle expectation is gnt=0, idx=0, valid=0.
    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                           input logic et);
        chk({tag, ".gnt"},       {4'b0, gnt},        {4'b0, eg});
        chk({tag, ".gnt_idx"},   {6'b0, gnt_idx},    {6'b0, ei});
        chk({tag, ".gnt_valid"}, {7'b0, gnt_valid},  {7'b0, |eg});
        chk({tag, ".timeout"},   {7'b0, timeout},    {7'b0, et});
    endtask

    task automatic chk_grant(input string tag, input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        chk_out(tag, oh, 2'(idx), 1'b0);
    endtask

    initial begin
        logic [1:0] rot [5];
        rot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        req   = 4'b1111;
        done  = 1'b0;

        // 1. Reset with all requests high.
        #2 rst_n = 1'b0;
        #1 chk_out("rst_async", 4'b0, 2'd0, 1'b0);
        step();
        chk_out("rst_hold1", 4'b0, 2'd0, 1'b0);
        step();
        chk_out("rst_hold2", 4'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b0100;

        // 2. Single request, then done.
        step();
        chk_grant("single", 2);
        done = 1'b1;
        step();
        chk_out("single_rel", 4'b0, 2'd0, 1'b0);
        done = 1'b0;
        // ptr is now 3: with everyone requesting, 3 wins.
        req = 4'b1111;
        step();
        chk_grant("ptr3", 3);
        step();
        chk_grant("ptr3_hold", 3);
        done = 1'b1;
        step();
        chk_out("ptr3_rel", 4'b0, 2'd0, 1'b0);
        done = 1'b0;

        // 3. Rotation with 2-cycle grants.
        for (int k = 0; k < 5; k++) begin
            step();
            chk_grant($sformatf("rot%0d_a", k), int'(rot[k]));
            step();
            chk_grant($sformatf("rot%0d_b", k), int'(rot[k]));
            done = 1'b1;
            step();
            chk_out($sformatf("rot%0d_gap", k), 4'b0, 2'd0, 1'b0);
            done = 1'b0;
        end

        // 4. Pointer priority (ptr=1 now).
        req = 4'b0010;
        step();
        chk_grant("prio_own1", 1);
        done = 1'b1;
        step();
        chk_out("prio_rel1", 4'b0, 2'd0, 1'b0);
        done = 1'b0;
        req  = 4'b0011;
        step();
        chk_grant("prio_scan230", 0);
        done = 1'b1;
        step();
        chk_out("prio_rel0", 4'b0, 2'd0, 1'b0);
        done = 1'b0;
        req  = 4'b1010;
        step();
        chk_grant("prio_1010", 1);
        done = 1'b1;
        step();
        chk_out("prio_rel1b", 4'b0, 2'd0, 1'b0);
        done = 1'b0;

        // 5. Timeout: 8 grant cycles, timeout pulse in the idle gap, regrant.
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk_grant($sformatf("to_hold%0d", c), 0);
        end
        step();
        chk_out("to_release", 4'b0, 2'd0, 1'b1);
        step();
        chk_grant("to_regrant", 0);

        // 6a. Owner drops request in cycle 3: release without timeout.
        step();
        chk_grant("drop_c2", 0);
        req = 4'b0000;
        step();
        chk_out("drop_rel", 4'b0, 2'd0, 1'b0);
        step();
        chk_out("idle_noreq", 4'b0, 2'd0, 1'b0);

        // done in IDLE is ignored, both with and without requests.
        done = 1'b1;
        step();
        chk_out("idle_done", 4'b0, 2'd0, 1'b0);
        req = 4'b0001;
        step();
        chk_grant("idle_done_req", 0);
        done = 1'b0;

        // 6b. done on the MAX_HOLD cycle: release, no timeout.
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_grant($sformatf("coll_hold%0d", c), 0);
        end
        done = 1'b1;
        step();
        chk_out("coll_rel", 4'b0, 2'd0, 1'b0);
        done = 1'b0;

        // Non-owner request changes are ignored (ptr=1).
        req = 4'b0100;
        step();
        chk_grant("nonown_g2", 2);
        req = 4'b1111;
        step();
        chk_grant("nonown_all", 2);
        req = 4'b0101;
        step();
        chk_grant("nonown_0101", 2);

        // Mid-cycle reset during a grant: immediate clear, ptr back to 0.
        req = 4'b1111;
        #3 rst_n = 1'b0;
        #1 chk_out("rst_mid", 4'b0, 2'd0, 1'b0);
        step();
        chk_out("rst_mid_hold", 4'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_grant("rst_ptr0", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
